// File: rtl/acc_0.sv
`default_nettype none
// ============================================================================
// acc_0 : Sobel edge-detection accelerator over a word-packed greyscale image.
//         Macro ACC_BORDER_CLEAR_EN: border pixels output 0x00 instead of input.
// Rev 1.0
// ============================================================================
module acc_0 #(
  parameter int IMG_W    = 352,
  parameter int IMG_H    = 288,
  parameter int OUT_BASE = IMG_W * IMG_H / 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] addr,
  input  logic [31:0] dataR,
  output logic [31:0] dataW,
  output logic        en,
  output logic        we,
  input  logic        start,
  output logic        finish
);

  localparam logic [15:0] c_WW     = 16'(IMG_W / 4);
  localparam logic [15:0] c_LAST_C = 16'(IMG_W / 4 - 1);
  localparam logic [15:0] c_LAST_R = 16'(IMG_H - 1);
  localparam logic [15:0] c_OUT    = 16'(OUT_BASE);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_PRIME = 3'd1;
  localparam logic [2:0] c_READ  = 3'd2;
  localparam logic [2:0] c_WRITE = 3'd3;
  localparam logic [2:0] c_NEXT  = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  logic [2:0]  r_state, w_state_nx;
  logic [2:0]  r_k;
  logic [15:0] r_row, r_col;
  logic [7:0]  r_wl [3];
  logic [31:0] r_wm [3];
  logic [31:0] r_wr [2];
  logic        w_last_c, w_first_r, w_last_r;
  logic [15:0] w_rsel, w_csel, w_addr_nx;
  logic [31:0] w_r2, w_dout, w_dw_nx;
  logic [47:0] w_top, w_mid, w_bot;
  logic        w_en_nx, w_we_nx, w_fin_nx;

  function automatic logic [7:0] f_sobel(input logic [7:0] t0, t1, t2, m0, m2, b0, b1, b2);
    logic [11:0]        xp, xn, yp, yn, ax, ay, s;
    logic signed [11:0] gx, gy;
    xp = {4'd0, t2} + {3'd0, m2, 1'b0} + {4'd0, b2};
    xn = {4'd0, t0} + {3'd0, m0, 1'b0} + {4'd0, b0};
    yp = {4'd0, b0} + {3'd0, b1, 1'b0} + {4'd0, b2};
    yn = {4'd0, t0} + {3'd0, t1, 1'b0} + {4'd0, t2};
    gx = $signed(xp) - $signed(xn);
    gy = $signed(yp) - $signed(yn);
    ax = gx[11] ? 12'(-gx) : 12'(gx);
    ay = gy[11] ? 12'(-gy) : 12'(gy);
    s  = ax + ay;
    return 8'(s >> 3);
  endfunction

  assign w_last_c  = (r_col == c_LAST_C);
  assign w_first_r = (r_row == 16'd0);
  assign w_last_r  = (r_row == c_LAST_R);
  // Column c+1 beyond the right edge contributes a zero word.
  assign w_r2      = w_last_c ? 32'd0 : dataR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nx = c_PRIME;
      c_PRIME: if (r_k == 3'd4) w_state_nx = c_READ;
      c_READ:  if (r_k == 3'd3) w_state_nx = c_WRITE;
      c_WRITE: w_state_nx = c_NEXT;
      c_NEXT: begin
        if (w_last_c && w_last_r) w_state_nx = c_DONE;
        else if (w_last_c)        w_state_nx = c_PRIME;
        else                      w_state_nx = c_READ;
      end
      c_DONE:  if (!start) w_state_nx = c_IDLE;
      default: w_state_nx = c_IDLE;
    endcase
  end

  always_comb begin
    w_rsel = r_row;
    if (r_k == 3'd0 && !w_first_r)     w_rsel = r_row - 16'd1;
    else if (r_k == 3'd2 && !w_last_r) w_rsel = r_row + 16'd1;
    w_csel = (r_state == c_PRIME) ? 16'd0 : r_col + 16'd1;
  end

  always_comb begin
    w_en_nx   = 1'b0;
    w_we_nx   = 1'b0;
    w_fin_nx  = 1'b0;
    w_addr_nx = addr;
    w_dw_nx   = dataW;
    case (r_state)
      c_PRIME, c_READ: begin
        if (r_k < 3'd3 && (r_state == c_PRIME || !w_last_c)) begin
          w_en_nx   = 1'b1;
          w_addr_nx = w_rsel * c_WW + w_csel;
        end
      end
      c_WRITE: begin
        w_en_nx   = 1'b1;
        w_we_nx   = 1'b1;
        w_addr_nx = c_OUT + r_row * c_WW + r_col;
        w_dw_nx   = w_dout;
      end
      c_NEXT:  w_fin_nx = w_last_c && w_last_r;
      c_DONE:  w_fin_nx = start;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en     <= 1'b0;
      we     <= 1'b0;
      finish <= 1'b0;
      addr   <= 16'd0;
      dataW  <= 32'd0;
    end else begin
      en     <= w_en_nx;
      we     <= w_we_nx;
      finish <= w_fin_nx;
      addr   <= w_addr_nx;
      dataW  <= w_dw_nx;
    end
  end

  // Read data lags issue by two cycles: rows r-1, r land at k=2,3; row r+1 at k=4 / WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k   <= 3'd0;
      r_row <= 16'd0;
      r_col <= 16'd0;
      for (int i = 0; i < 3; i++) begin
        r_wl[i] <= 8'd0;
        r_wm[i] <= 32'd0;
      end
      for (int i = 0; i < 2; i++) r_wr[i] <= 32'd0;
    end else begin
      r_k <= ((r_state == c_PRIME || r_state == c_READ) && w_state_nx == r_state) ? r_k + 3'd1 : 3'd0;
      case (r_state)
        c_IDLE: begin
          r_row <= 16'd0;
          r_col <= 16'd0;
        end
        c_PRIME: begin
          for (int i = 0; i < 3; i++) r_wl[i] <= 8'd0;
          if (r_k == 3'd2) r_wm[0] <= dataR;
          if (r_k == 3'd3) r_wm[1] <= dataR;
          if (r_k == 3'd4) r_wm[2] <= dataR;
        end
        c_READ: begin
          if (r_k == 3'd2) r_wr[0] <= w_r2;
          if (r_k == 3'd3) r_wr[1] <= w_r2;
        end
        c_WRITE: begin
          for (int i = 0; i < 3; i++) r_wl[i] <= r_wm[i][31:24];
          r_wm[0] <= r_wr[0];
          r_wm[1] <= r_wr[1];
          r_wm[2] <= w_r2;
        end
        c_NEXT: begin
          if (w_last_c) begin
            r_col <= 16'd0;
            r_row <= r_row + 16'd1;
          end else begin
            r_col <= r_col + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_top = {r_wr[0][7:0], r_wm[0], r_wl[0]};
  assign w_mid = {r_wr[1][7:0], r_wm[1], r_wl[1]};
  assign w_bot = {w_r2[7:0],    r_wm[2], r_wl[2]};

  always_comb begin
    w_dout = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (w_first_r || w_last_r || (j == 0 && r_col == 16'd0) || (j == 3 && w_last_c)) begin
`ifdef ACC_BORDER_CLEAR_EN
        w_dout[8*j +: 8] = 8'h00;
`else
        w_dout[8*j +: 8] = w_mid[8*(j+1) +: 8];
`endif
      end else begin
        w_dout[8*j +: 8] = f_sobel(w_top[8*j +: 8], w_top[8*(j+1) +: 8], w_top[8*(j+2) +: 8],
                                   w_mid[8*j +: 8], w_mid[8*(j+2) +: 8],
                                   w_bot[8*j +: 8], w_bot[8*(j+1) +: 8], w_bot[8*(j+2) +: 8]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_0.sv
`default_nettype none
// ============================================================================
// tb_acc_0 : randomized scoreboard bench for acc_0 on a reduced 32x12 image.
// Rev 1.0
// ============================================================================
module tb_acc_0;
  localparam int W  = 32;
  localparam int H  = 12;
  localparam int WW = W / 4;
  localparam int NW = WW * H;
  localparam int OB = NW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] addr;
  logic [31:0] dataR = 32'd0;
  logic [31:0] dataW;
  logic        en, we, finish;

  logic [31:0] mem [2*NW];
  logic [31:0] exp_mem [NW];
  logic [7:0]  img [H][W];
  logic [47:0] exp_q [$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int n_wr = 0;

  acc_0 #(.IMG_W(W), .IMG_H(H), .OUT_BASE(OB)) dut (
    .clk(clk), .reset(reset), .addr(addr), .dataR(dataR), .dataW(dataW),
    .en(en), .we(we), .start(start), .finish(finish)
  );

  always #5 clk = ~clk;

  function automatic int px(input int r, input int x);
    return int'(img[r][x]);
  endfunction

  function automatic logic [7:0] ref_pix(input int r, input int x);
    int gx, gy;
    if (r == 0 || r == H-1 || x == 0 || x == W-1) begin
`ifdef ACC_BORDER_CLEAR_EN
      return 8'h00;
`else
      return img[r][x];
`endif
    end
    gx = (px(r-1,x+1) + 2*px(r,x+1) + px(r+1,x+1)) - (px(r-1,x-1) + 2*px(r,x-1) + px(r+1,x-1));
    gy = (px(r+1,x-1) + 2*px(r+1,x) + px(r+1,x+1)) - (px(r-1,x-1) + 2*px(r-1,x) + px(r-1,x+1));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return 8'((gx + gy) / 8);
  endfunction

  function automatic logic [7:0] out_pix(input int r, input int x);
    logic [31:0] w;
    w = mem[OB + r*WW + x/4];
    return w[8*(x%4) +: 8];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Fill image + memory and queue the expected write stream (pat < 0 keeps img).
  task automatic load(input int pat);
    logic [31:0] w;
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++)
        case (pat)
          0: img[r][x] = 8'h00;
          1: img[r][x] = 8'($urandom_range(0, 255));
          2: img[r][x] = (x < W/2) ? 8'h00 : 8'hFF;
          3: img[r][x] = (r == 5 && x == 13) ? 8'hFF : 8'h00;
          4: img[r][x] = 8'h80;
          5: img[r][x] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
          default: ;
        endcase
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < WW; c++) begin
        mem[r*WW + c] = {img[r][4*c+3], img[r][4*c+2], img[r][4*c+1], img[r][4*c]};
        mem[OB + r*WW + c] = 32'hA5A5A5A5;
        w = {ref_pix(r, 4*c+3), ref_pix(r, 4*c+2), ref_pix(r, 4*c+1), ref_pix(r, 4*c)};
        exp_mem[r*WW + c] = w;
        exp_q.push_back({16'(OB + r*WW + c), w});
      end
    n_wr = 0;
  endtask

  task automatic run_check();
    int i;
    int bad;
    start = 1'b1;
    i = 0;
    while (!finish && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check("finish_reached", finish, 1);
    if (!finish) begin
      start = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      return;
    end
    check("finish_latency", 64'(cyc - last_wr_cyc), 1);
    check("queue_empty", exp_q.size(), 0);
    bad = 0;
    for (int k = 0; k < NW; k++) if (mem[OB + k] !== exp_mem[k]) bad++;
    check("out_region", bad, 0);
    bad = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < WW; c++)
        if (mem[r*WW + c] !== {img[r][4*c+3], img[r][4*c+2], img[r][4*c+1], img[r][4*c]}) bad++;
    check("in_region_intact", bad, 0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!finish || en) bad++;
    end
    check("done_hold_no_retrigger", bad, 0);
    start = 1'b0;
    @(negedge clk);
    check("finish_drop", finish, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
        if (en && int'(addr) < 2*NW) begin
          if (we) mem[addr] = dataW;
          else    dataR <= mem[addr];
        end
      end
      begin : monitor
        logic [47:0] e;
        forever begin
          @(negedge clk);
          if (!reset && en && we) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_write", {addr, dataW}, 48'h0);
            else begin
              e = exp_q.pop_front();
              check("write", {addr, dataW}, e);
            end
          end
        end
      end
    join_none

    begin : main
      int acc;
      repeat (2) @(negedge clk);
      check("reset_values", {en, we, finish, addr, dataW}, 0);
      reset = 1'b0;
      acc = 0;
      repeat (20) begin
        @(negedge clk);
        if (en) acc++;
      end
      check("idle_no_access", acc, 0);

      load(0); run_check();
      load(2); run_check();
      check("step_x15", out_pix(5, 15), 127);
      check("step_x16", out_pix(5, 16), 127);
      check("step_x10", out_pix(5, 10), 0);
      load(3); run_check();
      check("pix_right", out_pix(5, 14), 63);
      check("pix_diag", out_pix(6, 14), 63);
      check("pix_self", out_pix(5, 13), 0);
      load(4); run_check();
`ifndef ACC_BORDER_CLEAR_EN
      check("uniform_border", out_pix(0, 7), 8'h80);
`endif
      check("uniform_interior", out_pix(4, 9), 0);
      load(5); run_check();
      repeat (3) begin
        load(1); run_check();
      end

      load(1);
      start = 1'b1;
      acc = 0;
      while (n_wr < NW/2 && acc < 5000) begin
        @(negedge clk);
        acc++;
      end
      check("midrun_reached", n_wr >= NW/2, 1);
      #2 reset = 1'b1;
      #1 check("midrun_reset_values", {en, we, finish, addr, dataW}, 0);
      exp_q.delete();
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      load(-1);
      @(negedge clk);
      run_check();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

endmodule
`default_nettype wire
